// File: rtl/tsc_ring_capture.sv
// tsc_ring_capture: trigger-surround capture cache.
// Continuously writes ADC samples into a circular buffer. After PRE samples
// have been stored it arms, detects a threshold trigger in level or
// rising-edge mode, and keeps DEPTH-PRE-1 samples after the trigger. The
// trigger time is latched, and on request the frozen DEPTH-sample window is
// shifted out serially, oldest sample first, MSB first.
//
// Ports:
//   clk, reset   single clock; synchronous active-high reset
//   start        begin a capture run (IDLE only)
//   req          sample strobe qualifying adc_data
//   adc_data     ADC sample
//   trig_level   trigger threshold
//   trig_mode    0 = level, 1 = rising crossing
//   sbf          send-buffer request (DONE only)
//   trd          trigger detected (sticky until next start/reset)
//   cd           transfer complete (sticky until next start/reset)
//   trigtm       timer value at the trigger sample
//   sd, sd_valid serial data bit and its qualifier
//   busy         high outside IDLE
module tsc_ring_capture #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned PRE     = 16,
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               req,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_mode,
  input  logic               sbf,
  output logic               trd,
  output logic               cd,
  output logic [TIMER_W-1:0] trigtm,
  output logic               sd,
  output logic               sd_valid,
  output logic               busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [AW-1:0] LP_PRE    = AW'(PRE);
  localparam logic [AW-1:0] LP_PRE_M1 = AW'(PRE - 1);
  localparam logic [AW-1:0] LP_POST   = AW'(DEPTH - PRE - 1);
  localparam logic [BW-1:0] LP_MSB    = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_FILL, S_ARMED, S_POST, S_DONE, S_SEND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]  r_buf [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_fill;
  logic [AW-1:0]      r_post;
  logic [AW-1:0]      r_trig_idx;
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_scnt;
  logic [BW-1:0]      r_bit;
  logic [DATA_W-1:0]  r_prev;
  logic               r_prev_ok;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] r_trigtm;
  logic               r_trd;
  logic               r_cd;

  logic w_capture;
  logic w_store;
  logic w_trig;
  logic w_fill_done;
  logic w_post_done;
  logic w_bit_last;
  logic w_send_done;

  assign w_capture   = (r_state == S_PRE_FILL) || (r_state == S_ARMED) ||
                       (r_state == S_POST);
  assign w_store     = w_capture && req;
  // Rising mode needs a previous sample from this run to compare against.
  assign w_trig      = (r_state == S_ARMED) && req && (adc_data >= trig_level) &&
                       (!trig_mode || (r_prev_ok && (r_prev < trig_level)));
  assign w_fill_done = (r_state == S_PRE_FILL) && req && (r_fill == LP_PRE_M1);
  // r_post holds samples still to come; the store that empties it ends capture.
  assign w_post_done = (r_state == S_POST) && req && (r_post == AW'(1));
  assign w_bit_last  = (r_bit == '0);
  assign w_send_done = (r_state == S_SEND) && w_bit_last && (r_scnt == '1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start)       w_next = S_PRE_FILL;
      S_PRE_FILL: if (w_fill_done) w_next = S_ARMED;
      S_ARMED:    if (w_trig)      w_next = (LP_POST == '0) ? S_DONE : S_POST;
      S_POST:     if (w_post_done) w_next = S_DONE;
      S_DONE:     if (sbf)         w_next = S_SEND;
      S_SEND:     if (w_send_done) w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_store) r_buf[r_wr] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr       <= '0;
      r_fill     <= '0;
      r_post     <= '0;
      r_trig_idx <= '0;
      r_rd       <= '0;
      r_scnt     <= '0;
      r_bit      <= '0;
      r_prev     <= '0;
      r_prev_ok  <= 1'b0;
      r_timer    <= '0;
      r_trigtm   <= '0;
      r_trd      <= 1'b0;
      r_cd       <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_trd     <= 1'b0;
        r_cd      <= 1'b0;
        r_trigtm  <= '0;
        r_fill    <= '0;
        r_timer   <= '0;
        r_wr      <= '0;
        r_prev_ok <= 1'b0;
      end
      if (w_capture) r_timer <= r_timer + 1'b1;
      if (w_store) begin
        r_wr      <= r_wr + 1'b1;
        r_prev    <= adc_data;
        r_prev_ok <= 1'b1;
      end
      if ((r_state == S_PRE_FILL) && req) r_fill <= r_fill + 1'b1;
      if (w_trig) begin
        r_trig_idx <= r_wr;
        r_trigtm   <= r_timer;
        r_trd      <= 1'b1;
        r_post     <= LP_POST;
      end
      if ((r_state == S_POST) && req) r_post <= r_post - 1'b1;
      if ((r_state == S_DONE) && sbf) begin
        // Oldest kept sample sits PRE entries behind the trigger slot.
        r_rd   <= r_trig_idx - LP_PRE;
        r_bit  <= LP_MSB;
        r_scnt <= '0;
      end
      if (r_state == S_SEND) begin
        if (w_bit_last) begin
          r_bit  <= LP_MSB;
          r_rd   <= r_rd + 1'b1;
          r_scnt <= r_scnt + 1'b1;
        end else begin
          r_bit <= r_bit - 1'b1;
        end
        if (w_send_done) r_cd <= 1'b1;
      end
    end
  end

  assign trd      = r_trd;
  assign cd       = r_cd;
  assign trigtm   = r_trigtm;
  assign busy     = (r_state != S_IDLE);
  assign sd_valid = (r_state == S_SEND);
  assign sd       = sd_valid ? r_buf[r_rd][r_bit] : 1'b0;

endmodule

// File: tb/tb_tsc_ring_capture.sv
// tb_tsc_ring_capture: directed bench for tsc_ring_capture.
// Instance A uses the default geometry (8-bit, 32 deep, 16 pre-trigger);
// instance B uses 12-bit, 8 deep, 7 pre-trigger. Expected windows, trigger
// times and stream timing are hand-derived constants.
module tb_tsc_ring_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_start, a_req, a_mode, a_sbf;
  logic [7:0]  a_adc, a_level;
  logic        a_trd, a_cd, a_sd, a_sd_valid, a_busy;
  logic [31:0] a_trigtm;

  logic        b_start, b_req, b_mode, b_sbf;
  logic [11:0] b_adc, b_level;
  logic        b_trd, b_cd, b_sd, b_sd_valid, b_busy;
  logic [31:0] b_trigtm;

  tsc_ring_capture dut_a (
    .clk(clk), .reset(reset), .start(a_start), .req(a_req), .adc_data(a_adc),
    .trig_level(a_level), .trig_mode(a_mode), .sbf(a_sbf), .trd(a_trd),
    .cd(a_cd), .trigtm(a_trigtm), .sd(a_sd), .sd_valid(a_sd_valid),
    .busy(a_busy)
  );

  tsc_ring_capture #(.DATA_W(12), .DEPTH(8), .PRE(7), .TIMER_W(32)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .req(b_req), .adc_data(b_adc),
    .trig_level(b_level), .trig_mode(b_mode), .sbf(b_sbf), .trd(b_trd),
    .cd(b_cd), .trigtm(b_trigtm), .sd(b_sd), .sd_valid(b_sd_valid),
    .busy(b_busy)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  got_a [32];
  logic [7:0]  exp_a [32];
  logic [11:0] got_b [8];
  logic [11:0] exp_b [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic a_sample(input logic [7:0] d);
    a_req = 1'b1;
    a_adc = d;
    tick();
    a_req = 1'b0;
  endtask

  task automatic a_begin();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check_eq("busy_after_start", 64'(a_busy), 64'd1);
  endtask

  // sbf edge, then DEPTH*DATA_W bits on consecutive cycles, then cd.
  task automatic read_a(input string tag);
    int unsigned gaps;
    gaps = 0;
    a_sbf = 1'b1;
    tick();
    a_sbf = 1'b0;
    for (int w = 0; w < 32; w++) begin
      for (int b = 0; b < 8; b++) begin
        if (!a_sd_valid) gaps++;
        got_a[w] = {got_a[w][6:0], a_sd};
        if (!(w == 31 && b == 7)) tick();
      end
    end
    check_eq({tag, "_valid_gaps"}, 64'(gaps), 64'd0);
    check_eq({tag, "_cd_early"}, 64'(a_cd), 64'd0);
    tick();
    check_eq({tag, "_cd_end"}, 64'(a_cd), 64'd1);
    check_eq({tag, "_busy_end"}, 64'(a_busy), 64'd0);
    check_eq({tag, "_sdv_end"}, 64'(a_sd_valid), 64'd0);
    check_eq({tag, "_sd_end"}, 64'(a_sd), 64'd0);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_win[%0d]", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
  endtask

  initial begin
    int unsigned gaps;
    reset = 1'b1;
    a_start = 0; a_req = 0; a_mode = 0; a_sbf = 0; a_adc = '0; a_level = '0;
    b_start = 0; b_req = 0; b_mode = 0; b_sbf = 0; b_adc = '0; b_level = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", 64'(a_busy), 64'd0);
    check_eq("rst_trd", 64'(a_trd), 64'd0);
    check_eq("rst_cd", 64'(a_cd), 64'd0);
    check_eq("rst_trigtm", 64'(a_trigtm), 64'd0);
    check_eq("rst_sd", 64'(a_sd), 64'd0);
    check_eq("rst_sdv", 64'(a_sd_valid), 64'd0);
    check_eq("rst_b_busy", 64'(b_busy), 64'd0);

    // Ramp, level mode, threshold 0x28: window 0x18..0x37.
    a_mode = 1'b0;
    a_level = 8'h28;
    a_begin();
    for (int i = 0; i < 8'h28; i++) a_sample(8'(i));
    check_eq("ramp_trd_before", 64'(a_trd), 64'd0);
    a_sample(8'h28);
    check_eq("ramp_trd", 64'(a_trd), 64'd1);
    check_eq("ramp_trigtm", 64'(a_trigtm), 64'd40);
    for (int i = 8'h29; i <= 8'h37; i++) a_sample(8'(i));
    a_sample(8'hAA);  // DONE: must be ignored
    a_sample(8'hAB);
    for (int i = 0; i < 32; i++) exp_a[i] = 8'(8'h18 + i);
    read_a("ramp");
    check_eq("ramp_trd_held", 64'(a_trd), 64'd1);

    // 0xFF during fill ignored; 0xFF on req 20 after a 3-cycle gap triggers.
    a_begin();
    check_eq("start_clears_cd", 64'(a_cd), 64'd0);
    check_eq("start_clears_trd", 64'(a_trd), 64'd0);
    for (int i = 1; i <= 10; i++) a_sample(8'hFF);
    for (int i = 11; i <= 19; i++) a_sample(8'h00);
    check_eq("fill_trd_before", 64'(a_trd), 64'd0);
    tick(); tick(); tick();
    a_sample(8'hFF);
    check_eq("fill_trd", 64'(a_trd), 64'd1);
    check_eq("fill_trigtm", 64'(a_trigtm), 64'd22);
    for (int i = 0; i < 15; i++) a_sample(8'(8'h50 + i));
    for (int i = 0; i < 7; i++)  exp_a[i] = 8'hFF;
    for (int i = 7; i < 16; i++) exp_a[i] = 8'h00;
    exp_a[16] = 8'hFF;
    for (int i = 0; i < 15; i++) exp_a[17 + i] = 8'(8'h50 + i);
    read_a("fill");

    // Rising mode; sbf in ARMED and start in POST both ignored.
    a_mode = 1'b1;
    a_level = 8'hD5;
    a_begin();
    for (int i = 0; i < 20; i++) a_sample(8'hE0);
    check_eq("rise_const_trd", 64'(a_trd), 64'd0);
    a_sbf = 1'b1;
    tick();
    a_sbf = 1'b0;
    check_eq("sbf_armed_sdv", 64'(a_sd_valid), 64'd0);
    check_eq("sbf_armed_busy", 64'(a_busy), 64'd1);
    a_sample(8'h10);
    check_eq("rise_low_trd", 64'(a_trd), 64'd0);
    a_sample(8'hE0);
    check_eq("rise_trd", 64'(a_trd), 64'd1);
    check_eq("rise_trigtm", 64'(a_trigtm), 64'd22);
    a_sample(8'h01);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check_eq("start_post_trd", 64'(a_trd), 64'd1);
    check_eq("start_post_trigtm", 64'(a_trigtm), 64'd22);
    for (int i = 2; i <= 15; i++) a_sample(8'(i));
    for (int i = 0; i < 15; i++) exp_a[i] = 8'hE0;
    exp_a[15] = 8'h10;
    exp_a[16] = 8'hE0;
    for (int i = 0; i < 15; i++) exp_a[17 + i] = 8'(i + 1);
    read_a("rise");

    // 100 samples before the trigger: buffer wrapped several times.
    a_mode = 1'b0;
    a_level = 8'hF0;
    a_begin();
    for (int i = 0; i < 100; i++) a_sample(8'(i));
    check_eq("wrap_trd_before", 64'(a_trd), 64'd0);
    a_sample(8'hF5);
    check_eq("wrap_trigtm", 64'(a_trigtm), 64'd100);
    for (int i = 0; i < 15; i++) a_sample(8'(8'h80 + i));
    for (int i = 0; i < 16; i++) exp_a[i] = 8'(84 + i);
    exp_a[16] = 8'hF5;
    for (int i = 0; i < 15; i++) exp_a[17 + i] = 8'(8'h80 + i);
    read_a("wrap");

    // Reset in the middle of a transfer.
    a_begin();
    for (int i = 0; i < 16; i++) a_sample(8'h00);
    a_sample(8'hFF);
    check_eq("mid_trigtm", 64'(a_trigtm), 64'd16);
    for (int i = 0; i < 15; i++) a_sample(8'h0F);
    a_sbf = 1'b1;
    tick();
    a_sbf = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("mid_sdv", 64'(a_sd_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_sd", 64'(a_sd), 64'd0);
    check_eq("mid_rst_sdv", 64'(a_sd_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(a_busy), 64'd0);
    check_eq("mid_rst_trd", 64'(a_trd), 64'd0);
    check_eq("mid_rst_cd", 64'(a_cd), 64'd0);
    check_eq("mid_rst_trigtm", 64'(a_trigtm), 64'd0);

    // Instance B: PRE = DEPTH-1, trigger goes straight to DONE.
    b_mode = 1'b0;
    b_level = 12'h800;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      b_req = 1'b1; b_adc = 12'(12'h100 + i); tick();
    end
    b_adc = 12'h200; tick();
    b_adc = 12'h300; tick();
    b_adc = 12'hABC; tick();
    b_req = 1'b0;
    check_eq("b_trd", 64'(b_trd), 64'd1);
    check_eq("b_trigtm", 64'(b_trigtm), 64'd9);
    // sbf right after the trigger; the concurrent req must be ignored.
    b_sbf = 1'b1; b_req = 1'b1; b_adc = 12'h999;
    tick();
    b_sbf = 1'b0; b_req = 1'b0;
    check_eq("b_sdv_first", 64'(b_sd_valid), 64'd1);
    gaps = 0;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 12; b++) begin
        if (!b_sd_valid) gaps++;
        got_b[w] = {got_b[w][10:0], b_sd};
        if (!(w == 7 && b == 11)) tick();
      end
    end
    check_eq("b_valid_gaps", 64'(gaps), 64'd0);
    check_eq("b_cd_early", 64'(b_cd), 64'd0);
    tick();
    check_eq("b_cd_end", 64'(b_cd), 64'd1);
    check_eq("b_busy_end", 64'(b_busy), 64'd0);
    exp_b[0] = 12'h103; exp_b[1] = 12'h104; exp_b[2] = 12'h105;
    exp_b[3] = 12'h106; exp_b[4] = 12'h107; exp_b[5] = 12'h200;
    exp_b[6] = 12'h300; exp_b[7] = 12'hABC;
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("b_win[%0d]", i), 64'(got_b[i]), 64'(exp_b[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
